sprite_color_mapper: RTL and testbench
======================================

// Module: sprite_color_mapper
// PURPOSE
//  Parametrised, pipelined successor to the single-ball colour mapper for the VGA path.
//  Draws NUM_SPRITES solid sprites. Each sprite is a circle or a square, with its own colour.
//  Sprites sit over a horizontal blue-gradient background.
//  Sits between vga_controller (DrawX/DrawY/blank) and the VGA DAC pins.
//  Sprite parameters are frame-latched, so there is no tearing.
//  A per-frame sprite-overlap (collision) flag is reported to game logic.
// PARAMETERS
//  NUM_SPRITES  4   number of sprites, 1..8; index 0 has the highest priority
//  COORD_W      10  width of DrawX/DrawY/sprite X/Y/size
//  PIPE_LAT     3   fixed pixel-to-RGB latency; only 3 is supported (elaboration error otherwise)
// PORTS
//  Clk          in   1                   pixel clock
//  Reset_n      in   1                   asynchronous, active-low reset
//  pix_valid    in   1                   DrawX/DrawY are in the visible region (not blank)
//  frame_start  in   1                   1-cycle pulse once per frame, inside vertical blank
//  DrawX        in   COORD_W             current pixel column
//  DrawY        in   COORD_W             current pixel row
//  SpriteX      in   NUM_SPRITES*COORD_W centre X of each sprite, sprite i at [i*COORD_W +: COORD_W]
//  SpriteY      in   NUM_SPRITES*COORD_W centre Y of each sprite
//  SpriteSize   in   NUM_SPRITES*COORD_W radius (circle) or half-side (square)
//  SpriteMode   in   NUM_SPRITES         per sprite: 1 = circle, 0 = square
//  SpriteEn     in   NUM_SPRITES         per-sprite enable
//  SpriteRGB    in   NUM_SPRITES*24      per sprite {R,G,B}, 8 bits each
//  Red          out  8                   pixel red
//  Green        out  8                   pixel green
//  Blue         out  8                   pixel blue
//  rgb_valid    out  1                   pix_valid delayed by PIPE_LAT
//  hit_id       out  3                   index of the winning sprite; 7 when the pixel is background
//  collision    out  1                   >=2 sprites overlapped on a visible pixel in the last completed frame
// BEHAVIOUR
//  Reset (Reset_n=0, async):
//   - all pipeline registers, shadow registers and the collision accumulator clear to 0.
//   - Red/Green/Blue=0, rgb_valid=0, collision=0, hit_id=7.
//  Shadow latch: on any clock edge with frame_start=1, all Sprite* inputs are copied to shadow registers.
//   - The rest of the pipeline uses only shadow values, so mid-frame input changes are invisible.
//   - After reset, shadow SpriteEn=0, so only background is drawn until the first frame_start.
//  Stage 1 (reg):
//   - dx_i = DrawX - SpriteX_i and dy_i = DrawY - SpriteY_i, as signed COORD_W+1 bits.
//   - pix_valid and DrawX[9:3] travel alongside.
//  Stage 2 (reg), per-sprite hit_i = en_i & test. The test depends on mode:
//   - circle: dx^2 + dy^2 <= size^2, signed, 2*COORD_W+3 bits, no truncation.
//   - square: |dx| <= size && |dy| <= size.
//   - Edges are inclusive in both modes.
//   - Winner = lowest i with hit_i=1.
//   - multi_hit = popcount(hit) >= 2.
//   - Both winner and multi_hit are gated by the stage-1 pix_valid.
//  Stage 3 (reg): output mux.
//   - rgb_valid=0 -> RGB=0, hit_id=7.
//   - winner exists -> RGB = SpriteRGB[winner], hit_id = winner.
//   - otherwise -> Red=0, Green=0, Blue = 8'h7F - {3'b0, DrawX[9:3]} (8-bit wrap), hit_id=7.
//  Latency: a pixel presented at edge t appears on the outputs after edge t+3.
//   - The pipeline runs every cycle; there is no stall and no backpressure.
//  Collision: the accumulator is sticky and is ORed with stage-2 multi_hit.
//   - On frame_start: collision <= acc | multi_hit(this cycle), then acc <= 0.
//   - So a hit coincident with frame_start counts toward the frame that is ending.
//   - collision holds its value for the whole next frame.
//  Coordinates: sprites that are partly off screen (SpriteX < size, or beyond 639) clip naturally.
//   - There is no wrap-around, because the arithmetic is signed.
//  Reset mid-frame: outputs go to their reset values immediately.
//   - Drawing resumes as background until the next frame_start.
// TESTING
//  T1 reset: hold Reset_n=0 mid-stream, then release -> RGB=0, hit_id=7, collision=0; background only until the first frame_start.
//  T2 circle edge: sprite0 at (100,100), size 10, circle, RGB=FF5500; pulse frame_start.
//   - (110,100) -> FF5500 exactly 3 cycles later; (108,108) -> background (128>100).
//  T3 square vs circle: same setup with mode=0 -> (108,108) hits, (111,100) misses.
//  T4 priority: sprite0 and sprite1 overlap at (200,200) -> sprite0 colour, hit_id=0.
//   - Disable sprite0 -> sprite1 colour, hit_id=1.
//  T5 collision: overlap drawn in frame N -> collision=1 after the frame_start ending N.
//   - Overlap removed in frame N+1 -> collision=0 after the next frame_start.
//  T6 frame latch: change SpriteX mid-frame -> no pixel change until after frame_start.
//   - Blanking (pix_valid=0) -> RGB=0, rgb_valid=0.

Source files
------------

// File: rtl/sprite_color_mapper.sv
// Three-stage VGA colour mapper: frame-latched sprites (circle/square) over a blue gradient,
// with a per-frame sprite-overlap flag.
module sprite_color_mapper #(
    parameter int unsigned NUM_SPRITES = 4,
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned PIPE_LAT    = 3
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           pix_valid,
    input  logic                           frame_start,
    input  logic [COORD_W-1:0]             DrawX,
    input  logic [COORD_W-1:0]             DrawY,
    input  logic [NUM_SPRITES*COORD_W-1:0] SpriteX,
    input  logic [NUM_SPRITES*COORD_W-1:0] SpriteY,
    input  logic [NUM_SPRITES*COORD_W-1:0] SpriteSize,
    input  logic [NUM_SPRITES-1:0]         SpriteMode,
    input  logic [NUM_SPRITES-1:0]         SpriteEn,
    input  logic [NUM_SPRITES*24-1:0]      SpriteRGB,
    output logic [7:0]                     Red,
    output logic [7:0]                     Green,
    output logic [7:0]                     Blue,
    output logic                           rgb_valid,
    output logic [2:0]                     hit_id,
    output logic                           collision
);
    localparam int unsigned SqW = 2 * COORD_W + 3;

    if (PIPE_LAT != 3) begin : g_bad_lat
        $error("sprite_color_mapper: only PIPE_LAT=3 is supported");
    end
    if (NUM_SPRITES < 1 || NUM_SPRITES > 8) begin : g_bad_num
        $error("sprite_color_mapper: NUM_SPRITES must be 1..8");
    end
    if (COORD_W < 10) begin : g_bad_coord
        $error("sprite_color_mapper: COORD_W must be at least 10");
    end

    logic [NUM_SPRITES*COORD_W-1:0] sh_x_q, sh_y_q, sh_size_q;
    logic [NUM_SPRITES-1:0]         sh_mode_q, sh_en_q;
    logic [NUM_SPRITES*24-1:0]      sh_rgb_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_size_q <= '0;
            sh_mode_q <= '0;
            sh_en_q   <= '0;
            sh_rgb_q  <= '0;
        end else if (frame_start) begin
            sh_x_q    <= SpriteX;
            sh_y_q    <= SpriteY;
            sh_size_q <= SpriteSize;
            sh_mode_q <= SpriteMode;
            sh_en_q   <= SpriteEn;
            sh_rgb_q  <= SpriteRGB;
        end
    end

    // Stage 1: signed offsets from each sprite centre.
    logic signed [COORD_W:0] dx_d [NUM_SPRITES];
    logic signed [COORD_W:0] dy_d [NUM_SPRITES];
    logic signed [COORD_W:0] s1_dx_q [NUM_SPRITES];
    logic signed [COORD_W:0] s1_dy_q [NUM_SPRITES];
    logic                    s1_valid_q;
    logic [6:0]              s1_col_q;

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            dx_d[i] = $signed({1'b0, DrawX}) - $signed({1'b0, sh_x_q[i*COORD_W +: COORD_W]});
            dy_d[i] = $signed({1'b0, DrawY}) - $signed({1'b0, sh_y_q[i*COORD_W +: COORD_W]});
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                s1_dx_q[i] <= '0;
                s1_dy_q[i] <= '0;
            end
            s1_valid_q <= 1'b0;
            s1_col_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                s1_dx_q[i] <= dx_d[i];
                s1_dy_q[i] <= dy_d[i];
            end
            s1_valid_q <= pix_valid;
            s1_col_q   <= DrawX[9:3];
        end
    end

    function automatic logic sprite_hit(input logic signed [COORD_W:0] dx,
                                        input logic signed [COORD_W:0] dy,
                                        input logic [COORD_W-1:0]      size,
                                        input logic                    circle);
        logic signed [SqW-1:0] dxe, dye, r;
        logic [COORD_W:0]      ax, ay;
        dxe = dx;
        dye = dy;
        r   = $signed({{(SqW-COORD_W){1'b0}}, size});
        ax  = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        ay  = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        if (circle) return (dxe * dxe + dye * dye) <= (r * r);
        return (ax <= {1'b0, size}) && (ay <= {1'b0, size});
    endfunction

    // Stage 2: per-sprite hit test, priority winner and overlap detection.
    logic [NUM_SPRITES-1:0] hit;
    logic                   win_found;
    logic [2:0]             win_id;
    logic [3:0]             hit_cnt;
    logic                   s2_valid_q, s2_found_q, s2_multi_q;
    logic [2:0]             s2_id_q;
    logic [6:0]             s2_col_q;

    always_comb begin
        hit       = '0;
        win_found = 1'b0;
        win_id    = '0;
        hit_cnt   = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit[i] = sh_en_q[i] & sprite_hit(s1_dx_q[i], s1_dy_q[i],
                                             sh_size_q[i*COORD_W +: COORD_W], sh_mode_q[i]);
            if (hit[i] && !win_found) begin
                win_found = 1'b1;
                win_id    = 3'(i);
            end
            hit_cnt = hit_cnt + {3'b0, hit[i]};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_valid_q <= 1'b0;
            s2_found_q <= 1'b0;
            s2_multi_q <= 1'b0;
            s2_id_q    <= '0;
            s2_col_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_found_q <= s1_valid_q & win_found;
            s2_multi_q <= s1_valid_q & (hit_cnt >= 4'd2);
            s2_id_q    <= win_id;
            s2_col_q   <= s1_col_q;
        end
    end

    // Stage 3: output mux.
    logic [23:0] rgb_d;
    logic [2:0]  id_d;

    always_comb begin
        rgb_d = '0;
        id_d  = 3'd7;
        if (s2_valid_q) begin
            if (s2_found_q) begin
                rgb_d = sh_rgb_q[int'(s2_id_q)*24 +: 24];
                id_d  = s2_id_q;
            end else begin
                rgb_d = {16'h0, 8'h7F - {1'b0, s2_col_q}};
            end
        end
    end

    logic acc_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            rgb_valid <= 1'b0;
            hit_id    <= 3'd7;
            acc_q     <= 1'b0;
            collision <= 1'b0;
        end else begin
            {Red, Green, Blue} <= rgb_d;
            rgb_valid          <= s2_valid_q;
            hit_id             <= id_d;
            // An overlap landing on the frame_start cycle belongs to the frame that is ending.
            if (frame_start) begin
                collision <= acc_q | s2_multi_q;
                acc_q     <= 1'b0;
            end else begin
                acc_q     <= acc_q | s2_multi_q;
            end
        end
    end
endmodule

// File: tb/tb_sprite_color_mapper.sv
// Bench for sprite_color_mapper: directed vector table, corner sequences and randomized
// pixels checked against an integer reference model.
module tb_sprite_color_mapper;
    localparam int N  = 4;
    localparam int CW = 10;

    logic            Clk = 1'b0, Reset_n = 1'b0, pix_valid = 1'b0, frame_start = 1'b0;
    logic [CW-1:0]   DrawX = '0, DrawY = '0;
    logic [N*CW-1:0] SpriteX = '0, SpriteY = '0, SpriteSize = '0;
    logic [N-1:0]    SpriteMode = '0, SpriteEn = '0;
    logic [N*24-1:0] SpriteRGB = '0;
    logic [7:0]      Red, Green, Blue;
    logic            rgb_valid, collision;
    logic [2:0]      hit_id;

    sprite_color_mapper #(.NUM_SPRITES(N), .COORD_W(CW), .PIPE_LAT(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
        .SpriteSize(SpriteSize), .SpriteMode(SpriteMode), .SpriteEn(SpriteEn),
        .SpriteRGB(SpriteRGB), .Red(Red), .Green(Green), .Blue(Blue),
        .rgb_valid(rgb_valid), .hit_id(hit_id), .collision(collision)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    typedef struct { logic [23:0] rgb; logic [2:0] id; logic v; int tag; } exp_t;
    exp_t exp_q[$];

    // Model copy of the frame-latched sprite set.
    int          sh_x[N], sh_y[N], sh_s[N];
    bit          sh_m[N], sh_e[N];
    logic [23:0] sh_rgb[N];
    bit          m_acc = 0, m_coll = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic void model(input int x, input int y, input bit v,
                                  output exp_t e, output int nhit);
        int dx, dy, s;
        bit h;
        e.v = v; e.rgb = '0; e.id = 3'd7; e.tag = 0; nhit = 0;
        if (!v) return;
        e.rgb = {16'h0, 8'(127 - x / 8)};
        for (int i = 0; i < N; i++) begin
            dx = x - sh_x[i];
            dy = y - sh_y[i];
            s  = sh_s[i];
            if (sh_m[i]) h = (dx * dx + dy * dy) <= s * s;
            else         h = (dx <= s) && (-dx <= s) && (dy <= s) && (-dy <= s);
            if (sh_e[i] && h) begin
                if (nhit == 0) begin
                    e.rgb = sh_rgb[i];
                    e.id  = 3'(i);
                end
                nhit++;
            end
        end
    endfunction

    task automatic step(input int x, input int y, input bit v, input bit fs,
                        input bit use_exp, input logic [23:0] erg, input logic [2:0] eid,
                        input int tag);
        exp_t e;
        int   nh;
        @(negedge Clk);
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            chk($sformatf("pix%0d", e.tag), {4'h0, rgb_valid, hit_id, Red, Green, Blue},
                {4'h0, e.v, e.id, e.rgb});
        end
        chk("collision", {31'h0, collision}, {31'h0, m_coll});
        DrawX = CW'(x); DrawY = CW'(y); pix_valid = v; frame_start = fs;
        model(x, y, v, e, nh);
        if (use_exp) begin e.rgb = erg; e.id = eid; end
        e.tag = tag;
        if (nh >= 2) m_acc = 1;
        if (fs) begin
            m_coll = m_acc; m_acc = 0;
            for (int i = 0; i < N; i++) begin
                sh_x[i] = int'(SpriteX[i*CW +: CW]);
                sh_y[i] = int'(SpriteY[i*CW +: CW]);
                sh_s[i] = int'(SpriteSize[i*CW +: CW]);
                sh_m[i] = SpriteMode[i];
                sh_e[i] = SpriteEn[i];
                sh_rgb[i] = SpriteRGB[i*24 +: 24];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic pix(input int x, input int y, input int tag);
        step(x, y, 1, 0, 0, '0, '0, tag);
    endtask

    task automatic pix_e(input int x, input int y, input logic [23:0] rgb, input logic [2:0] id,
                         input int tag);
        step(x, y, 1, 0, 1, rgb, id, tag);
    endtask

    task automatic blank();
        step(0, 0, 0, 0, 0, '0, '0, -1);
    endtask

    // Drain the pipeline, then pulse frame_start during blanking.
    task automatic frame_pulse();
        repeat (3) blank();
        step(0, 0, 0, 1, 0, '0, '0, -2);
    endtask

    task automatic set_sprite(input int i, input int x, input int y, input int s, input bit m,
                              input bit en, input logic [23:0] rgb);
        SpriteX[i*CW +: CW] = CW'(x);
        SpriteY[i*CW +: CW] = CW'(y);
        SpriteSize[i*CW +: CW] = CW'(s);
        SpriteMode[i] = m;
        SpriteEn[i] = en;
        SpriteRGB[i*24 +: 24] = rgb;
    endtask

    task automatic apply_cfg(input int c);
        for (int i = 0; i < N; i++) set_sprite(i, 0, 0, 0, 0, 0, 24'h0);
        case (c)
            0: set_sprite(0, 100, 100, 10, 1, 1, 24'hFF5500);
            1: set_sprite(0, 100, 100, 10, 0, 1, 24'hFF5500);
            2, 3: begin
                set_sprite(0, 200, 200, 20, 0, c == 2, 24'h00FF00);
                set_sprite(1, 205, 205, 20, 1, 1, 24'h0000FF);
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("rst_out", {4'h0, rgb_valid, hit_id, Red, Green, Blue}, {4'h0, 1'b0, 3'd7, 24'h0});
        chk("rst_coll", {31'h0, collision}, 32'h0);
        exp_q.delete();
        for (int i = 0; i < N; i++) sh_e[i] = 0;
        m_acc = 0; m_coll = 0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    typedef struct { int cfg; int x; int y; bit v; logic [23:0] rgb; logic [2:0] id; } vec_t;
    vec_t tbl[12];

    initial begin
        int cur;
        tbl[0]  = '{0, 110, 100, 1, 24'hFF5500, 3'd0};
        tbl[1]  = '{0, 108, 108, 1, 24'h000072, 3'd7};
        tbl[2]  = '{0, 100,  90, 1, 24'hFF5500, 3'd0};
        tbl[3]  = '{0, 100,  89, 1, 24'h000073, 3'd7};
        tbl[4]  = '{0, 110, 100, 0, 24'h000000, 3'd7};
        tbl[5]  = '{1, 108, 108, 1, 24'hFF5500, 3'd0};
        tbl[6]  = '{1, 111, 100, 1, 24'h000072, 3'd7};
        tbl[7]  = '{1,  90, 110, 1, 24'hFF5500, 3'd0};
        tbl[8]  = '{2, 200, 200, 1, 24'h00FF00, 3'd0};
        tbl[9]  = '{2, 222, 200, 1, 24'h0000FF, 3'd1};
        tbl[10] = '{3, 200, 200, 1, 24'h0000FF, 3'd1};
        tbl[11] = '{3, 230, 205, 1, 24'h000063, 3'd7};

        for (int i = 0; i < N; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_s[i] = 0; sh_m[i] = 0; sh_e[i] = 0; sh_rgb[i] = '0;
        end
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;

        // Background only before any frame_start, even with sprites on the inputs.
        apply_cfg(0);
        pix_e(110, 100, 24'h000072, 3'd7, 100);

        cur = -1;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].cfg != cur) begin
                cur = tbl[i].cfg;
                apply_cfg(cur);
                frame_pulse();
            end
            step(tbl[i].x, tbl[i].y, tbl[i].v, 0, 1, tbl[i].rgb, tbl[i].id, i);
        end

        // Overlap in frame N sets collision; a clean frame N+1 clears it.
        apply_cfg(2);
        frame_pulse();
        pix_e(202, 202, 24'h00FF00, 3'd0, 200);
        set_sprite(1, 400, 400, 20, 1, 1, 24'h0000FF);
        frame_pulse();
        blank();
        chk("t5_set", {31'h0, collision}, 32'h1);
        pix_e(200, 200, 24'h00FF00, 3'd0, 201);
        frame_pulse();
        blank();
        chk("t5_clear", {31'h0, collision}, 32'h0);

        // Asynchronous reset with collision set and hits in flight.
        apply_cfg(2);
        frame_pulse();
        pix(202, 202, 300);
        frame_pulse();
        blank();
        chk("t1_pre", {31'h0, collision}, 32'h1);
        pix(200, 200, 301);
        pix(205, 205, 302);
        do_reset();
        apply_cfg(0);
        pix_e(110, 100, 24'h000072, 3'd7, 303);
        pix_e(100, 100, 24'h00007F - 24'd12, 3'd7, 304);
        frame_pulse();
        pix_e(110, 100, 24'hFF5500, 3'd0, 305);

        // Sprite inputs moved mid-frame stay invisible until frame_start.
        SpriteX[0 +: CW] = CW'(300);
        pix_e(110, 100, 24'hFF5500, 3'd0, 400);
        pix_e(300, 100, 24'h00005A, 3'd7, 401);
        frame_pulse();
        pix_e(110, 100, 24'h000072, 3'd7, 402);
        pix_e(300, 100, 24'hFF5500, 3'd0, 403);
        step(300, 100, 0, 0, 1, 24'h0, 3'd7, 404);

        // Randomized sprite sets (including off-screen clipping) against the model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++)
                set_sprite(i, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                           int'($urandom_range(0, 40)), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                           24'($urandom));
            frame_pulse();
            for (int k = 0; k < 150; k++) begin
                int j, px, py, s;
                j  = int'($urandom_range(0, N - 1));
                s  = sh_s[j];
                px = sh_x[j] + int'($urandom_range(0, 2 * s + 4)) - s - 2;
                py = sh_y[j] + int'($urandom_range(0, 2 * s + 4)) - s - 2;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                step(px, py, $urandom_range(0, 9) != 0, 0, 0, '0, '0, 1000 + r * 1000 + k);
            end
        end
        frame_pulse();
        repeat (3) blank();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
